core_memory_interface: RTL and testbench

//  Routes core pipeline memory traffic to the memory subsystem.
//  - Fetch stage requests go to the instruction memory/cache.
//  - Memory stage loads/stores go to the data memory/cache.
//  - Returned data, address, valid and ready are routed back to each stage.

---
 rtl/core_memory_interface.sv | 123 ++++++++++++
 tb/tb_core_memory_interface.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_memory_interface.sv
// core_memory_interface
// Zero-latency combinational router between the core pipeline stages and the
// instruction / data memories, plus a small clocked block of debug counters
// and an optional simulation-only scan trace.
module core_memory_interface #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  // fetch stage side
  input  logic                      fetch_read,
  input  logic [ADDRESS_BITS-1:0]   fetch_address_out,
  output logic [DATA_WIDTH-1:0]     fetch_data_in,
  output logic [ADDRESS_BITS-1:0]   fetch_address_in,
  output logic                      fetch_valid,
  output logic                      fetch_ready,
  // memory stage side
  input  logic                      memory_read,
  input  logic                      memory_write,
  input  logic [DATA_WIDTH/8-1:0]   memory_byte_en,
  input  logic [ADDRESS_BITS-1:0]   memory_address_out,
  input  logic [DATA_WIDTH-1:0]     memory_data_out,
  output logic [DATA_WIDTH-1:0]     memory_data_in,
  output logic [ADDRESS_BITS-1:0]   memory_address_in,
  output logic                      memory_valid,
  output logic                      memory_ready,
  // instruction memory side
  input  logic [DATA_WIDTH-1:0]     i_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   i_mem_address_out,
  input  logic                      i_mem_valid,
  input  logic                      i_mem_ready,
  output logic                      i_mem_read,
  output logic [ADDRESS_BITS-1:0]   i_mem_address_in,
  // data memory side
  input  logic [DATA_WIDTH-1:0]     d_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  input  logic                      d_mem_valid,
  input  logic                      d_mem_ready,
  output logic                      d_mem_read,
  output logic                      d_mem_write,
  output logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_in,
  // debug
  input  logic                      scan
);

  // Request strobes are gated by reset so nothing reaches memory while the
  // core is held in reset; address/data/response fields always pass through.
  // Simultaneous read and write are forwarded as-is for the data memory to
  // arbitrate.
  assign i_mem_read        = fetch_read & reset;
  assign i_mem_address_in  = fetch_address_out;

  assign fetch_data_in     = i_mem_data_out;
  assign fetch_address_in  = i_mem_address_out;
  assign fetch_valid       = i_mem_valid;
  assign fetch_ready       = i_mem_ready;

  assign d_mem_read        = memory_read & reset;
  assign d_mem_write       = memory_write & reset;
  assign d_mem_byte_en     = memory_byte_en;
  assign d_mem_address_in  = memory_address_out;
  assign d_mem_data_in     = memory_data_out;

  assign memory_data_in    = d_mem_data_out;
  assign memory_address_in = d_mem_address_out;
  assign memory_valid      = d_mem_valid;
  assign memory_ready      = d_mem_ready;

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] load_cnt_q,  load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  // Next-state for the debug counters: cycle counter free-runs and wraps,
  // the others count the gated strobes actually presented to memory.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    fetch_cnt_d = fetch_cnt_q + {31'd0, i_mem_read};
    load_cnt_d  = load_cnt_q  + {31'd0, d_mem_read};
    store_cnt_d = store_cnt_q + {31'd0, d_mem_write};
  end

  // Debug counter registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only scan trace of every port inside the configured cycle window.
  always @(posedge clock) begin
    if (scan &&
        (longint'(cycle_cnt_q) >= longint'(SCAN_CYCLES_MIN)) &&
        (longint'(cycle_cnt_q) <= longint'(SCAN_CYCLES_MAX))) begin
      $display("scan cyc=%0d rst=%b f_rd=%b f_ao=%h f_di=%h f_ai=%h f_v=%b f_r=%b m_rd=%b m_wr=%b m_be=%h m_ao=%h m_do=%h m_di=%h m_ai=%h m_v=%b m_r=%b",
               cycle_cnt_q, reset, fetch_read, fetch_address_out, fetch_data_in,
               fetch_address_in, fetch_valid, fetch_ready, memory_read, memory_write,
               memory_byte_en, memory_address_out, memory_data_out, memory_data_in,
               memory_address_in, memory_valid, memory_ready);
      $display("scan cyc=%0d im_do=%h im_ao=%h im_v=%b im_r=%b im_rd=%b im_ai=%h dm_do=%h dm_ao=%h dm_v=%b dm_r=%b dm_rd=%b dm_wr=%b dm_be=%h dm_ai=%h dm_di=%h",
               cycle_cnt_q, i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready,
               i_mem_read, i_mem_address_in, d_mem_data_out, d_mem_address_out,
               d_mem_valid, d_mem_ready, d_mem_read, d_mem_write, d_mem_byte_en,
               d_mem_address_in, d_mem_data_in);
    end
  end
`endif

endmodule

// File: tb/tb_core_memory_interface.sv
// Testbench for core_memory_interface: routing scoreboard plus debug counters.
module tb_core_memory_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_read;
  logic [31:0] fetch_address_out;
  logic [31:0] fetch_data_in, fetch_address_in;
  logic        fetch_valid, fetch_ready;
  logic        memory_read, memory_write;
  logic [3:0]  memory_byte_en;
  logic [31:0] memory_address_out, memory_data_out;
  logic [31:0] memory_data_in, memory_address_in;
  logic        memory_valid, memory_ready;
  logic [31:0] i_mem_data_out, i_mem_address_out;
  logic        i_mem_valid, i_mem_ready;
  logic        i_mem_read;
  logic [31:0] i_mem_address_in;
  logic [31:0] d_mem_data_out, d_mem_address_out;
  logic        d_mem_valid, d_mem_ready;
  logic        d_mem_read, d_mem_write;
  logic [3:0]  d_mem_byte_en;
  logic [31:0] d_mem_address_in, d_mem_data_in;
  logic        scan;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  core_memory_interface dut (
    .clock(clock), .reset(reset),
    .fetch_read(fetch_read), .fetch_address_out(fetch_address_out),
    .fetch_data_in(fetch_data_in), .fetch_address_in(fetch_address_in),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_byte_en(memory_byte_en), .memory_address_out(memory_address_out),
    .memory_data_out(memory_data_out), .memory_data_in(memory_data_in),
    .memory_address_in(memory_address_in), .memory_valid(memory_valid),
    .memory_ready(memory_ready),
    .i_mem_data_out(i_mem_data_out), .i_mem_address_out(i_mem_address_out),
    .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready),
    .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_byte_en(d_mem_byte_en), .d_mem_address_in(d_mem_address_in),
    .d_mem_data_in(d_mem_data_in), .scan(scan)
  );

  typedef struct packed {
    logic        i_rd;
    logic [31:0] i_addr;
    logic [31:0] f_data;
    logic [31:0] f_addr;
    logic        f_valid;
    logic        f_ready;
    logic        d_rd;
    logic        d_wr;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic [31:0] m_data;
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_ready;
  } resp_t;

  resp_t sb[$];

  // Reference counters kept by the bench from the stimulus it drives.
  logic [31:0] exp_cycle, exp_fetch, exp_load, exp_store;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_cycle <= 32'd0;
      exp_fetch <= 32'd0;
      exp_load  <= 32'd0;
      exp_store <= 32'd0;
    end else begin
      exp_cycle <= exp_cycle + 32'd1;
      if (fetch_read)   exp_fetch <= exp_fetch + 32'd1;
      if (memory_read)  exp_load  <= exp_load  + 32'd1;
      if (memory_write) exp_store <= exp_store + 32'd1;
    end
  end

  function automatic resp_t predict();
    resp_t r;
    r.i_rd    = (reset === 1'b1) ? fetch_read : 1'b0;
    r.i_addr  = fetch_address_out;
    r.f_data  = i_mem_data_out;
    r.f_addr  = i_mem_address_out;
    r.f_valid = i_mem_valid;
    r.f_ready = i_mem_ready;
    r.d_rd    = (reset === 1'b1) ? memory_read  : 1'b0;
    r.d_wr    = (reset === 1'b1) ? memory_write : 1'b0;
    r.d_be    = memory_byte_en;
    r.d_addr  = memory_address_out;
    r.d_data  = memory_data_out;
    r.m_data  = d_mem_data_out;
    r.m_addr  = d_mem_address_out;
    r.m_valid = d_mem_valid;
    r.m_ready = d_mem_ready;
    return r;
  endfunction

  function automatic resp_t observe();
    resp_t r;
    r.i_rd    = i_mem_read;
    r.i_addr  = i_mem_address_in;
    r.f_data  = fetch_data_in;
    r.f_addr  = fetch_address_in;
    r.f_valid = fetch_valid;
    r.f_ready = fetch_ready;
    r.d_rd    = d_mem_read;
    r.d_wr    = d_mem_write;
    r.d_be    = d_mem_byte_en;
    r.d_addr  = d_mem_address_in;
    r.d_data  = d_mem_data_in;
    r.m_data  = memory_data_in;
    r.m_addr  = memory_address_in;
    r.m_valid = memory_valid;
    r.m_ready = memory_ready;
    return r;
  endfunction

  task automatic idle_inputs();
    fetch_read = 0; fetch_address_out = 0;
    memory_read = 0; memory_write = 0; memory_byte_en = 0;
    memory_address_out = 0; memory_data_out = 0;
    i_mem_data_out = 0; i_mem_address_out = 0; i_mem_valid = 0; i_mem_ready = 0;
    d_mem_data_out = 0; d_mem_address_out = 0; d_mem_valid = 0; d_mem_ready = 0;
    scan = 0;
  endtask

  task automatic test_reset();
    resp_t e, o;
    @(negedge clock);
    reset = 1'b0;
    fetch_read = 1; memory_read = 1; memory_write = 1;
    fetch_address_out = 32'h0badf00d; memory_address_out = 32'h00c0ffee;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL reset_route got %h want %h", o, e);
    end
    compared++;
    if ({i_mem_read, d_mem_read, d_mem_write} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_strobes got %b want 000", {i_mem_read, d_mem_read, d_mem_write});
    end
    compared++;
    if (i_mem_address_in !== 32'h0badf00d || d_mem_address_in !== 32'h00c0ffee) begin
      mismatched++;
      $display("FAIL reset_addr_pass got %h/%h want 0badf00d/00c0ffee", i_mem_address_in, d_mem_address_in);
    end
    @(posedge clock); #1;
    compared++;
    if ({dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q} !== 128'd0) begin
      mismatched++;
      $display("FAIL reset_counters got %h %h %h %h want all 0",
               dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q);
    end
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_fetch_request();
    resp_t e, o;
    @(negedge clock);
    fetch_read = 1; fetch_address_out = 32'h11111111;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL fetch_req_route got %h want %h", o, e);
    end
    compared++;
    if (i_mem_read !== 1'b1 || i_mem_address_in !== 32'h11111111) begin
      mismatched++;
      $display("FAIL fetch_req got rd=%b addr=%h want rd=1 addr=11111111", i_mem_read, i_mem_address_in);
    end
  endtask

  task automatic test_fetch_response();
    resp_t e, o;
    @(negedge clock);
    i_mem_data_out = 32'h22222222; i_mem_address_out = 32'h11111111;
    i_mem_valid = 1; i_mem_ready = 1;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL fetch_rsp_route got %h want %h", o, e);
    end
    compared++;
    if ({fetch_data_in, fetch_address_in, fetch_valid, fetch_ready} !== {32'h22222222, 32'h11111111, 2'b11}) begin
      mismatched++;
      $display("FAIL fetch_rsp got %h %h %b %b want 22222222 11111111 1 1",
               fetch_data_in, fetch_address_in, fetch_valid, fetch_ready);
    end
  endtask

  task automatic test_store();
    resp_t e, o;
    @(negedge clock);
    fetch_read = 0;
    memory_write = 1; memory_read = 0; memory_byte_en = 4'b1010;
    memory_address_out = 32'h12341234; memory_data_out = 32'h99999999;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL store_route got %h want %h", o, e);
    end
    compared++;
    if ({d_mem_write, d_mem_read, d_mem_byte_en, d_mem_address_in, d_mem_data_in} !==
        {2'b10, 4'b1010, 32'h12341234, 32'h99999999}) begin
      mismatched++;
      $display("FAIL store got wr=%b rd=%b be=%h addr=%h data=%h want 1 0 a 12341234 99999999",
               d_mem_write, d_mem_read, d_mem_byte_en, d_mem_address_in, d_mem_data_in);
    end
  endtask

  task automatic test_load_response();
    resp_t e, o;
    @(negedge clock);
    memory_write = 0; memory_read = 1;
    d_mem_data_out = 32'h10002000; d_mem_address_out = 32'haabbccdd;
    d_mem_valid = 1; d_mem_ready = 1;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e) begin
      mismatched++;
      $display("FAIL load_rsp_route got %h want %h", o, e);
    end
    compared++;
    if ({memory_data_in, memory_address_in, memory_valid, memory_ready, d_mem_read} !==
        {32'h10002000, 32'haabbccdd, 3'b111}) begin
      mismatched++;
      $display("FAIL load_rsp got %h %h %b %b rd=%b want 10002000 aabbccdd 1 1 rd=1",
               memory_data_in, memory_address_in, memory_valid, memory_ready, d_mem_read);
    end
  endtask

  task automatic test_simultaneous();
    resp_t e, o;
    @(negedge clock);
    memory_read = 1; memory_write = 1; fetch_read = 1;
    sb.push_back(predict());
    #1;
    e = sb.pop_front(); o = observe();
    compared++;
    if (o !== e || {d_mem_read, d_mem_write} !== 2'b11) begin
      mismatched++;
      $display("FAIL simultaneous_rw got %h want %h", o, e);
    end
    @(negedge clock);
    compared++;
    if ({dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q} !==
        {exp_cycle, exp_fetch, exp_load, exp_store}) begin
      mismatched++;
      $display("FAIL counters_after_traffic got %0d %0d %0d %0d want %0d %0d %0d %0d",
               dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q,
               exp_cycle, exp_fetch, exp_load, exp_store);
    end
  endtask

  task automatic test_fetch_count();
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    fetch_read = 1;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    compared++;
    if (dut.fetch_cnt_q !== 32'd5) begin
      mismatched++;
      $display("FAIL fetch_count got %0d want 5", dut.fetch_cnt_q);
    end
    compared++;
    if (dut.cycle_cnt_q !== 32'd5 || dut.load_cnt_q !== 32'd0) begin
      mismatched++;
      $display("FAIL cycle_count got cyc=%0d load=%0d want 5 0", dut.cycle_cnt_q, dut.load_cnt_q);
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (dut.fetch_cnt_q !== 32'd0 || dut.cycle_cnt_q !== 32'd0) begin
      mismatched++;
      $display("FAIL async_clear got fetch=%0d cyc=%0d want 0 0", dut.fetch_cnt_q, dut.cycle_cnt_q);
    end
    @(negedge clock);
    fetch_read = 0;
    reset = 1'b1;
  endtask

  task automatic test_random();
    resp_t e, o;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      fetch_read = 1'($urandom); memory_read = 1'($urandom); memory_write = 1'($urandom);
      memory_byte_en = 4'($urandom);
      fetch_address_out = $urandom; memory_address_out = $urandom; memory_data_out = $urandom;
      i_mem_data_out = $urandom; i_mem_address_out = $urandom;
      i_mem_valid = 1'($urandom); i_mem_ready = 1'($urandom);
      d_mem_data_out = $urandom; d_mem_address_out = $urandom;
      d_mem_valid = 1'($urandom); d_mem_ready = 1'($urandom);
      sb.push_back(predict());
      #1;
      e = sb.pop_front(); o = observe();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL random_route[%0d] got %h want %h", i, o, e);
      end
    end
    @(negedge clock);
    compared++;
    if ({dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q} !==
        {exp_cycle, exp_fetch, exp_load, exp_store}) begin
      mismatched++;
      $display("FAIL random_counters got %0d %0d %0d %0d want %0d %0d %0d %0d",
               dut.cycle_cnt_q, dut.fetch_cnt_q, dut.load_cnt_q, dut.store_cnt_q,
               exp_cycle, exp_fetch, exp_load, exp_store);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    test_reset();
    test_fetch_request();
    test_fetch_response();
    test_store();
    test_load_response();
    test_simultaneous();
    test_fetch_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
